// File: rtl/counter_seq_ctrl.sv
// Command-driven wide up-counter with incrementally tracked residues mod MOD_A and MOD_B.
// Optional compare/match output enabled by defining COUNTER_SEQ_MATCH_EN.
module counter_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int MOD_A = 3,
  parameter int MOD_B = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic                     abort,
`ifdef COUNTER_SEQ_MATCH_EN
  input  logic [WIDTH-1:0]         cmp_val,
  output logic                     match,
`endif
  output logic [WIDTH-1:0]         cnt,
  output logic [$clog2(MOD_A)-1:0] res_a,
  output logic [$clog2(MOD_B)-1:0] res_b,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int RA_W = $clog2(MOD_A);
  localparam int RB_W = $clog2(MOD_B);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic             accept;
  logic             clr;
  logic             inc;
  logic             wrap;
  logic [WIDTH-1:0] cnt_inc;

  function automatic logic [RA_W-1:0] res_a_inc(input logic [RA_W-1:0] r);
    return (r == RA_W'(MOD_A - 1)) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [RB_W-1:0] res_b_inc(input logic [RB_W-1:0] r);
    return (r == RB_W'(MOD_B - 1)) ? '0 : r + 1'b1;
  endfunction

  assign cmd_ready = (state == IDLE);

  always_comb begin
    accept  = (state == IDLE) && cmd_valid;
    clr     = accept && (cmd_op == OP_CLEAR);
    inc     = (state == RUN) ? !abort : (accept && (cmd_op == OP_STEP));
    cnt_inc = cnt + 1'b1;
    wrap    = &cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      cnt     <= '0;
      res_a   <= '0;
      res_b   <= '0;
`ifdef COUNTER_SEQ_MATCH_EN
      match   <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (cmd_op == OP_RUN)) begin
            if (cmd_data == '0) begin
              done <= 1'b1;
            end else begin
              rem   <= cmd_data;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort beats the final increment: no count, aborted pulse only
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            rem <= rem - 1'b1;
            if (rem == WIDTH'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
      endcase

      // residues restart at zero on counter wrap so they stay equal to cnt mod M
      if (clr) begin
        cnt   <= '0;
        res_a <= '0;
        res_b <= '0;
      end else if (inc) begin
        cnt   <= cnt_inc;
        res_a <= wrap ? '0 : res_a_inc(res_a);
        res_b <= wrap ? '0 : res_b_inc(res_b);
      end

`ifdef COUNTER_SEQ_MATCH_EN
      match <= inc && (cnt_inc == cmp_val);
`endif
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: vector table, directed corner sequences, randomized run vs model.
module tb_counter_seq_ctrl;
  localparam int W     = 5;
  localparam int MOD_A = 3;
  localparam int MOD_B = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         abort = 1'b0;
  logic [W-1:0] cnt;
  logic [1:0]   res_a;
  logic [2:0]   res_b;
  logic         busy, done, aborted;
`ifdef COUNTER_SEQ_MATCH_EN
  logic [W-1:0] cmp_val = '0;
  logic         match;
`endif

  counter_seq_ctrl #(.WIDTH(W), .MOD_A(MOD_A), .MOD_B(MOD_B)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort),
`ifdef COUNTER_SEQ_MATCH_EN
    .cmp_val(cmp_val), .match(match),
`endif
    .cnt(cnt), .res_a(res_a), .res_b(res_b),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: counter value as an integer, RUN progress as a count of increments left
  int m_cnt = 0;
  int m_left = 0;
  bit m_done = 0;
  bit m_ab = 0;
  bit m_match = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit bump;
    bump = 0;
    if (rst) begin
      m_cnt = 0; m_left = 0; m_done = 0; m_ab = 0; m_match = 0;
    end else begin
      m_done = 0; m_ab = 0;
      if (m_left > 0) begin
        if (abort) begin
          m_left = 0; m_ab = 1;
        end else begin
          bump = 1;
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          2'd0: m_cnt = 0;
          2'd1: if (cmd_data == 0) m_done = 1; else m_left = int'(cmd_data);
          2'd2: bump = 1;
          default: ;
        endcase
      end
      if (bump) m_cnt = (m_cnt + 1) % (1 << W);
`ifdef COUNTER_SEQ_MATCH_EN
      m_match = bump && (m_cnt == int'(cmp_val));
`endif
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] op, input int data, input bit ab);
    rst = r; cmd_valid = v; cmd_op = op; cmd_data = W'(data); abort = ab;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0);
  endtask

  task automatic chk_model();
    chk("rand_cnt", 32'(cnt), 32'(m_cnt));
    chk("rand_res_a", 32'(res_a), 32'(m_cnt % MOD_A));
    chk("rand_res_b", 32'(res_b), 32'(m_cnt % MOD_B));
    chk("rand_busy", 32'(busy), 32'(m_left > 0));
    chk("rand_ready", 32'(cmd_ready), 32'(m_left == 0));
    chk("rand_done", 32'(done), 32'(m_done));
    chk("rand_aborted", 32'(aborted), 32'(m_ab));
`ifdef COUNTER_SEQ_MATCH_EN
    chk("rand_match", 32'(match), 32'(m_match));
`endif
  endtask

  typedef struct {
    bit r; bit v; logic [1:0] op; int data; bit ab;
    int e_cnt; bit e_busy; bit e_done; bit e_ab;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int nb, nd, na, nm;
    bit wrap_seen;

    tbl[0]  = '{1, 0, 2'd0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 2'd0, 0, 0,  0, 0, 0, 0};
    tbl[2]  = '{0, 1, 2'd2, 0, 0,  1, 0, 0, 0};
    tbl[3]  = '{0, 1, 2'd2, 0, 0,  2, 0, 0, 0};
    tbl[4]  = '{0, 1, 2'd1, 0, 0,  2, 0, 1, 0};
    tbl[5]  = '{0, 0, 2'd0, 0, 0,  2, 0, 0, 0};
    tbl[6]  = '{0, 1, 2'd0, 0, 0,  0, 0, 0, 0};
    tbl[7]  = '{0, 1, 2'd3, 5, 0,  0, 0, 0, 0};
    tbl[8]  = '{0, 1, 2'd2, 0, 1,  1, 0, 0, 0};
    tbl[9]  = '{0, 1, 2'd1, 2, 1,  1, 1, 0, 0};
    tbl[10] = '{0, 1, 2'd2, 0, 0,  2, 1, 0, 0};
    tbl[11] = '{0, 0, 2'd0, 0, 0,  3, 0, 1, 0};
    tbl[12] = '{0, 0, 2'd0, 0, 0,  3, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].data, tbl[i].ab);
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_res_a", i), 32'(res_a), 32'(tbl[i].e_cnt % MOD_A));
      chk($sformatf("vec%0d_res_b", i), 32'(res_b), 32'(tbl[i].e_cnt % MOD_B));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(!tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_aborted", i), 32'(aborted), 32'(tbl[i].e_ab));
    end

    // normal RUN of 10 from zero
    step(1, 0, 2'd0, 0, 0);
    step(1, 0, 2'd0, 0, 0);
    step(0, 1, 2'd1, 10, 0);
    nb = busy ? 1 : 0; nd = 0; na = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 2'd0, 0, 0);
      if (busy) nb++;
      if (done) nd++;
      if (aborted) na++;
    end
    chk("run10_busy_cycles", 32'(nb), 32'd10);
    chk("run10_done_pulses", 32'(nd), 32'd1);
    chk("run10_aborted_pulses", 32'(na), 32'd0);
    chk("run10_cnt", 32'(cnt), 32'd10);
    chk("run10_res_a", 32'(res_a), 32'd1);
    chk("run10_res_b", 32'(res_b), 32'd3);

    // wrap: 33 increments from zero on a 5-bit counter pass 31 -> 0 -> 1
    step(0, 1, 2'd0, 0, 0);
    step(0, 1, 2'd1, 31, 0);
    idle(32);
    chk("wrap_pre_cnt", 32'(cnt), 32'd31);
    step(0, 1, 2'd1, 2, 0);
    wrap_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 2'd0, 0, 0);
      if (cnt == 0 && !wrap_seen) begin
        wrap_seen = 1;
        chk("wrap_res_a", 32'(res_a), 32'd0);
        chk("wrap_res_b", 32'(res_b), 32'd0);
      end
    end
    chk("wrap_seen", 32'(wrap_seen), 32'd1);
    chk("wrap_final_cnt", 32'(cnt), 32'd1);
    chk("wrap_final_res_a", 32'(res_a), 32'd1);
    chk("wrap_final_res_b", 32'(res_b), 32'd1);

    // abort at edge T+5 of a RUN of 20 accepted at T
    step(0, 1, 2'd0, 0, 0);
    step(0, 1, 2'd1, 20, 0);
    idle(4);
    step(0, 0, 2'd0, 0, 1);
    chk("abort_cnt", 32'(cnt), 32'd4);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    step(0, 0, 2'd0, 0, 0);
    chk("abort_pulse_end", 32'(aborted), 32'd0);
    chk("abort_done_after", 32'(done), 32'd0);
    chk("abort_cnt_hold", 32'(cnt), 32'd4);

    // CLEAR from 9, then STEP
    step(0, 1, 2'd0, 0, 0);
    step(0, 1, 2'd1, 9, 0);
    idle(10);
    chk("nine_cnt", 32'(cnt), 32'd9);
    step(0, 1, 2'd0, 0, 0);
    chk("clear_cnt", 32'(cnt), 32'd0);
    step(0, 1, 2'd2, 0, 0);
    chk("step_cnt", 32'(cnt), 32'd1);
    chk("step_res_b", 32'(res_b), 32'd1);

    // command held valid through a RUN of 3 is only taken once IDLE again
    step(0, 1, 2'd1, 3, 0);
    step(0, 1, 2'd2, 0, 0);
    chk("hold_t1_cnt", 32'(cnt), 32'd2);
    chk("hold_t1_ready", 32'(cmd_ready), 32'd0);
    step(0, 1, 2'd2, 0, 0);
    chk("hold_t2_cnt", 32'(cnt), 32'd3);
    step(0, 1, 2'd2, 0, 0);
    chk("hold_t3_cnt", 32'(cnt), 32'd4);
    chk("hold_t3_done", 32'(done), 32'd1);
    step(0, 1, 2'd2, 0, 0);
    chk("hold_step_cnt", 32'(cnt), 32'd5);
    chk("hold_step_done", 32'(done), 32'd0);

    // reset in the middle of a RUN
    step(0, 1, 2'd1, 10, 0);
    idle(3);
    step(1, 0, 2'd0, 0, 0);
    chk("rstrun_cnt", 32'(cnt), 32'd0);
    chk("rstrun_res_a", 32'(res_a), 32'd0);
    chk("rstrun_res_b", 32'(res_b), 32'd0);
    chk("rstrun_busy", 32'(busy), 32'd0);
    chk("rstrun_ready", 32'(cmd_ready), 32'd1);
    step(0, 0, 2'd0, 0, 0);
    chk("rstrun_done", 32'(done), 32'd0);
    chk("rstrun_aborted", 32'(aborted), 32'd0);
    chk("rstrun_cnt_after", 32'(cnt), 32'd0);

`ifdef COUNTER_SEQ_MATCH_EN
    cmp_val = W'(5);
    step(0, 1, 2'd0, 0, 0);
    chk("match_clear", 32'(match), 32'd0);
    step(0, 1, 2'd1, 8, 0);
    nm = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 2'd0, 0, 0);
      if (match) begin
        nm++;
        chk("match_cnt", 32'(cnt), 32'd5);
      end
    end
    chk("match_pulses", 32'(nm), 32'd1);
`endif

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      int data;
`ifdef COUNTER_SEQ_MATCH_EN
      if (i % 64 == 0) cmp_val = W'($urandom_range(0, (1 << W) - 1));
`endif
      data = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << W) - 1))
                                         : int'($urandom_range(0, 6));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), data, $urandom_range(0, 19) == 0);
      chk_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
